// File: rtl/mfu_pkg.sv
// Shared types for the multi-precision fusion unit and its accumulation stage.
package mfu_pkg;

   localparam int ACC_W_DEF = 32;
   localparam int CNT_W_DEF = 12;

   typedef enum logic [1:0] {
      MODE_8X8  = 2'b00,
      MODE_4X4  = 2'b01,
      MODE_2X2  = 2'b10,
      MODE_NOOP = 2'b11
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } acc_state_t;

endpackage

// File: rtl/mfu_accumulator_if.sv
// Product stream in, finished dot-product result out, plus group control.
interface mfu_acc_if
   import mfu_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);

   logic                    clear;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [15:0]      in_p;
   mode_t                   in_mode;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;
   logic [CNT_W-1:0]        out_count;
   mode_t                   out_mode;
   logic                    out_sat;
   logic                    err_mode;

   // Upstream/downstream environment view.
   modport master (
      output clear, in_valid, in_p, in_mode, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_mode, out_sat, err_mode
   );

   // Accumulator view.
   modport slave (
      input  clear, in_valid, in_p, in_mode, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_mode, out_sat, err_mode
   );

endinterface

// File: rtl/mfu_accumulator_sat_add.sv
// Signed saturating adder: clamps to the W-bit range and flags the clamp.
module sat_add #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                ovf
);

   logic [W:0] full;

   // NOTE: always_comb assigns every output on every path, so no latch is inferred.
   always_comb begin
      full = {a[W-1], a} + {b[W-1], b};
      ovf  = full[W] ^ full[W-1];
      sum  = full[W-1:0];
      if (ovf) begin
         // The extra sign bit tells which rail was crossed.
         sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mfu_accumulator.sv
// Per-PE output-stationary accumulator: sums one dot product per group and
// hands it to the drain path through a one-entry result buffer.
module mfu_accumulator
   import mfu_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic    clk,
   input logic    rst,
   mfu_acc_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   acc_state_t              state, state_next;
   logic signed [ACC_W-1:0] acc, acc_sum, acc_next, p_ext;
   logic [CNT_W-1:0]        count, count_next;
   logic                    sat_hit, sat_hit_next, add_ovf;
   mode_t                   grp_mode, mode_close;
   logic                    accept, close, first, noop, mismatch;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignment so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      if (bus.clear) begin
         state_next = IDLE;
      end else if (accept) begin
         if (bus.in_last)
            state_next = IDLE;
         else if (state == IDLE && !noop)
            state_next = RUN;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.in_ready = !bus.clear && (!bus.out_valid || bus.out_ready);
      accept       = bus.in_valid && bus.in_ready;
      close        = accept && bus.in_last;
      first        = (state == IDLE);
   end

   // ---------------- datapath ----------------
   assign p_ext = {{(ACC_W-16){bus.in_p[15]}}, bus.in_p};

   sat_add #(.W(ACC_W)) u_sat_add (
      .a   (acc),
      .b   (p_ext),
      .sum (acc_sum),
      .ovf (add_ovf)
   );

   always_comb begin
      noop         = (bus.in_mode == MODE_NOOP);
      acc_next     = noop ? acc : acc_sum;
      sat_hit_next = sat_hit || (!noop && add_ovf);
      count_next   = count;
      if (!noop && count != CNT_MAX) count_next = count + 1'b1;
      mode_close   = first ? bus.in_mode : grp_mode;
      // In RUN the group mode is never NOOP, so only real modes can conflict.
      mismatch     = !first && !noop && (bus.in_mode != grp_mode);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         count    <= '0;
         sat_hit  <= 1'b0;
         grp_mode <= MODE_NOOP;
         bus.err_mode <= 1'b0;
      end else if (bus.clear) begin
         acc      <= '0;
         count    <= '0;
         sat_hit  <= 1'b0;
         bus.err_mode <= 1'b0;
      end else if (accept) begin
         if (first) grp_mode <= bus.in_mode;
         if (mismatch) bus.err_mode <= 1'b1;
         // Closing beat restarts the group so the next beat needs no bubble.
         if (close) begin
            acc     <= '0;
            count   <= '0;
            sat_hit <= 1'b0;
         end else begin
            acc     <= acc_next;
            count   <= count_next;
            sat_hit <= sat_hit_next;
         end
      end
   end

   // ---------------- output buffer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_count <= '0;
         bus.out_mode  <= MODE_NOOP;
         bus.out_sat   <= 1'b0;
      end else if (close) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= acc_next;
         bus.out_count <= count_next;
         bus.out_mode  <= mode_close;
         bus.out_sat   <= sat_hit_next;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mfu_accumulator.sv
// Scoreboard bench for mfu_accumulator (ACC_W = 18, CNT_W = 4).
module tb_mfu_accumulator;
   import mfu_pkg::*;

   localparam int ACC_W = 18;
   localparam int CNT_W = 4;

   typedef struct {
      longint data;
      int     count;
      int     mode;
      int     sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   mfu_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   mfu_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input longint d, input int c, input int m, input int s);
      exp_t e;
      e.data = d; e.count = c; e.mode = m; e.sat = s;
      sb.push_back(e);
   endtask

   // Drive one beat and hold it until the DUT accepts it; returns at posedge+1.
   task automatic send_beat(input int p, input mode_t m, input logic last);
      int  n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_p     = 16'(p);
      bus.in_mode  = m;
      bus.in_last  = last;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("beat_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", sb.size(), 0);
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      check("clear_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
   endtask

   // Result monitor: a transfer happens at the next posedge when valid && ready.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("sb_empty_pop", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_data",  longint'($signed(bus.out_data)), e.data);
            check("res_count", bus.out_count, e.count);
            check("res_mode",  bus.out_mode, e.mode);
            check("res_sat",   bus.out_sat, e.sat);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_p      = '0;
      bus.in_mode   = MODE_8X8;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data, 0);
      check("rst_out_count", bus.out_count, 0);
      check("rst_out_mode",  bus.out_mode, 3);
      check("rst_out_sat",   bus.out_sat, 0);
      check("rst_err_mode",  bus.err_mode, 0);
      check("rst_in_ready",  bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Basic 8x8 group and one-cycle latency.
      push_exp(75, 3, 0, 0);
      send_beat(100, MODE_8X8, 1'b0);
      send_beat(-30, MODE_8X8, 1'b0);
      check("lat_before_last", bus.out_valid, 0);
      send_beat(5, MODE_8X8, 1'b1);
      check("lat_after_last", bus.out_valid, 1);
      wait_drain();

      // Positive and negative saturation.
      push_exp(131071, 5, 0, 1);
      for (int i = 0; i < 5; i++) send_beat(32767, MODE_8X8, i == 4);
      push_exp(-131072, 5, 2, 1);
      for (int i = 0; i < 5; i++) send_beat(-32768, MODE_2X2, i == 4);
      wait_drain();

      // Backpressure: A held, B not lost.
      bus.out_ready = 1'b0;
      push_exp(8, 2, 0, 0);
      push_exp(2, 1, 0, 0);
      send_beat(4, MODE_8X8, 1'b0);
      send_beat(4, MODE_8X8, 1'b1);
      fork
         send_beat(2, MODE_8X8, 1'b1);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("bp_in_ready", bus.in_ready, 0);
               check("bp_hold_data", bus.out_data, 8);
               check("bp_hold_valid", bus.out_valid, 1);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      wait_drain();

      // Back-to-back single-beat groups at full rate.
      push_exp(1, 1, 0, 0);
      push_exp(2, 1, 0, 0);
      push_exp(3, 1, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         send_beat(i, MODE_8X8, 1'b1);
         check("b2b_valid", bus.out_valid, 1);
      end
      wait_drain();

      // Mode mismatch and NOOP inside a group.
      push_exp(8, 2, 1, 0);
      send_beat(7, MODE_4X4, 1'b0);
      send_beat(50, MODE_NOOP, 1'b0);
      check("err_before_mismatch", bus.err_mode, 0);
      send_beat(1, MODE_2X2, 1'b1);
      check("err_set", bus.err_mode, 1);
      wait_drain();
      repeat (2) @(posedge clk);
      #1;
      check("err_sticky", bus.err_mode, 1);
      pulse_clear();
      check("err_cleared", bus.err_mode, 0);

      // NOOP-only group.
      push_exp(0, 0, 3, 0);
      send_beat(9, MODE_NOOP, 1'b0);
      send_beat(50, MODE_NOOP, 1'b1);
      wait_drain();

      // Count saturates at 2^CNT_W-1 while data keeps summing.
      push_exp(17, 15, 1, 0);
      for (int i = 0; i < 17; i++) send_beat(1, MODE_4X4, i == 16);
      wait_drain();

      // Clear mid-group discards the partial sum.
      send_beat(10, MODE_8X8, 1'b0);
      send_beat(20, MODE_8X8, 1'b0);
      pulse_clear();
      push_exp(3, 1, 0, 0);
      send_beat(3, MODE_8X8, 1'b1);
      wait_drain();

      // Asynchronous reset while a result is waiting.
      bus.out_ready = 1'b0;
      send_beat(5, MODE_4X4, 1'b1);
      check("pre_rst_valid", bus.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", bus.out_valid, 0);
      check("async_rst_data",  bus.out_data, 0);
      check("async_rst_mode",  bus.out_mode, 3);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);
      check("sb_final_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
